// File: rtl/pipeline_hazard_ctrl.sv
// Five-stage pipeline sequencer: stage hold enables, bubbles, redirects,
// halt drain and saturating stall/flush counters. Clocked on the negedge.
module pipeline_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             valid_id,
    input  logic [4:0]       rs1_id,
    input  logic [4:0]       rs2_id,
    input  logic             uses_rs1_id,
    input  logic             uses_rs2_id,
    input  logic             halt_id,
    input  logic             valid_ex,
    input  logic             load_ex,
    input  logic             RWrEn_ex,
    input  logic [4:0]       Rdst_ex,
    input  logic             redirect_ex,
    input  logic             mem_req_mem,
    input  logic             mem_ready,
    input  logic             valid_wb,
    input  logic             halt_wb,
    output logic             WEN_pc,
    output logic             WEN_ifid,
    output logic             WEN_idex,
    output logic             WEN_exmem,
    output logic             WEN_memwb,
    output logic             kill_if,
    output logic             kill_id,
    output logic             pc_sel,
    output logic             halted,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [1:0] RUN    = 2'd0;
    localparam logic [1:0] DRAIN  = 2'd1;
    localparam logic [1:0] HALTED = 2'd2;

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;
    logic             lu;
    logic             ms;
    logic             rd;
    logic             src_hit;
    logic             active;
    logic             stall_inc;
    logic             flush_inc;

    assign src_hit = (uses_rs1_id && rs1_id == Rdst_ex) ||
                     (uses_rs2_id && rs2_id == Rdst_ex);
    assign lu = valid_ex && load_ex && RWrEn_ex &&
                (Rdst_ex != 5'd0) && valid_id && src_hit;
    assign ms = mem_req_mem && !mem_ready;
    assign rd = valid_ex && redirect_ex;

    assign active    = (state_q != HALTED);
    assign stall_inc = active && (ms || (lu && !rd));
    assign flush_inc = active && rd && !ms;

    always_comb begin
        WEN_pc    = 1'b0;
        WEN_ifid  = 1'b0;
        WEN_idex  = 1'b0;
        WEN_exmem = 1'b0;
        WEN_memwb = 1'b0;
        kill_if   = 1'b0;
        kill_id   = 1'b0;
        pc_sel    = 1'b0;
        if (!RST || !active) begin
            WEN_pc    = 1'b1;
            WEN_ifid  = 1'b1;
            WEN_idex  = 1'b1;
            WEN_exmem = 1'b1;
            WEN_memwb = 1'b1;
        end else begin
            priority case (1'b1)
                ms: begin
                    WEN_pc    = 1'b1;
                    WEN_ifid  = 1'b1;
                    WEN_idex  = 1'b1;
                    WEN_exmem = 1'b1;
                    WEN_memwb = 1'b1;
                end
                rd: begin
                    pc_sel  = 1'b1;
                    kill_if = 1'b1;
                    kill_id = 1'b1;
                end
                lu: begin
                    WEN_pc   = 1'b1;
                    WEN_ifid = 1'b1;
                    kill_id  = 1'b1;
                end
                default: ;
            endcase
            // Draining stops fetch but lets older work flow out
            if (state_q == DRAIN && !ms) begin
                WEN_pc  = 1'b1;
                kill_if = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN: begin
                if (valid_id && halt_id && !ms && !rd && !lu)
                    state_d = DRAIN;
            end
            DRAIN: begin
                if (valid_wb && halt_wb && !ms)
                    state_d = HALTED;
            end
            HALTED:  state_d = HALTED;
            default: state_d = RUN;
        endcase
    end

    always_ff @(negedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= RUN;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            if (stall_inc && stall_q != '1)
                stall_q <= stall_q + CNT_W'(1);
            if (flush_inc && flush_q != '1)
                flush_q <= flush_q + CNT_W'(1);
        end
    end

    assign halted    = RST && (state_q == HALTED);
    assign state     = state_q;
    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central sequencing controller for the five-stage pipeline. It drives the per-stage hold enables (`WEN`) of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers, and it injects bubbles by forcing stage valid bits low. It resolves load-use stalls, EX-stage redirects (taken branch or jump), data-memory wait states and halt drain. It also keeps saturating stall and flush performance counters.

## Interface
Parameters:
- `CNT_W`, default 16: width of the performance counters.

Ports:
- `CLK` input 1: clock. State and counters update on the negative edge, the same edge as the pipeline registers.
- `RST` input 1: asynchronous, active-low reset.
- `valid_id` input 1: ID stage holds a real instruction.
- `rs1_id`, `rs2_id` input 5 each: ID source register numbers.
- `uses_rs1_id`, `uses_rs2_id` input 1 each: the ID instruction reads that source.
- `halt_id` input 1: the ID instruction is a halt.
- `valid_ex` input 1: EX stage holds a real instruction.
- `load_ex` input 1: the EX instruction is a load (write-back selects memory data).
- `RWrEn_ex` input 1: the EX instruction writes a register.
- `Rdst_ex` input 5: EX destination register.
- `redirect_ex` input 1: the EX instruction is a taken branch or a jump.
- `mem_req_mem` input 1: a valid data-memory access is in MEM.
- `mem_ready` input 1: data memory completes the access this cycle.
- `valid_wb`, `halt_wb` input 1 each: a halt has reached write-back.
- `WEN_pc`, `WEN_ifid`, `WEN_idex`, `WEN_exmem`, `WEN_memwb` output 1 each: 1 = hold the register, 0 = load it.
- `kill_if` output 1: forces `valid_if` = 0 into IF/ID.
- `kill_id` output 1: forces `valid_id` = 0 into ID/EX (bubble).
- `pc_sel` output 1: 1 = the PC loads the EX redirect target.
- `halted` output 1: the core has retired its halt.
- `state` output 2: current FSM state, for debug.
- `stall_cnt` output `CNT_W`: count of stall cycles.
- `flush_cnt` output `CNT_W`: count of redirects.

## Operation
Derived conditions, all combinational:
- **lu** (load-use): `valid_ex & load_ex & RWrEn_ex & Rdst_ex != 0 & valid_id & ((uses_rs1_id & rs1_id == Rdst_ex) | (uses_rs2_id & rs2_id == Rdst_ex))`.
- **ms** (memory stall): `mem_req_mem & !mem_ready`.
- **rd** (redirect): `valid_ex & redirect_ex`.

FSM states are RUN = 0, DRAIN = 1, HALTED = 2. Encoding 3 is illegal and goes to RUN.

Output rules apply in RUN and DRAIN, in priority order:
1. **ms**: all five `WEN` = 1, kills = 0, `pc_sel` = 0. The whole pipe freezes. A pending **rd** or **lu** is re-evaluated after release, because EX and ID are frozen.
2. **rd**: all `WEN` = 0, `pc_sel` = 1, `kill_if` = 1, `kill_id` = 1. Both wrong-path instructions are squashed. **rd** overrides **lu**.
3. **lu**: `WEN_pc` = `WEN_ifid` = 1, `kill_id` = 1, `WEN_idex`/`WEN_exmem`/`WEN_memwb` = 0. Exactly one bubble is inserted.
4. Otherwise all `WEN` = 0 and kills = 0.

DRAIN adds two overrides on top of rules 2–4: `WEN_pc` = 1 and `kill_if` = 1. No new instructions are fetched and older ones flow out.

HALTED: all `WEN` = 1, kills = 0, `pc_sel` = 0, `halted` = 1. This state is sticky until reset.

Transitions, taken at the negedge:
- RUN → DRAIN when `valid_id & halt_id & !ms & !rd & !lu`.
- DRAIN → HALTED when `valid_wb & halt_wb & !ms`.
- All other cases hold the current state.

Counters:
- `stall_cnt` increments in RUN/DRAIN on any cycle where **ms** holds, or where **lu** holds without **rd**.
- `flush_cnt` increments on **rd** without **ms**.
- Both counters saturate at 2^`CNT_W`−1 and never wrap.
- Both counters are frozen in HALTED.

## Timing
- Outputs are combinational from `state` and the current inputs, and must settle before the next negedge. There is zero latency from hazard to control.
- State and counters are registered on the negedge of `CLK`.
- A load-use stall lasts exactly 1 cycle unless **ms** extends it. The following cycle has the load in MEM, so **lu** is false.
- A redirect costs 2 bubbles: IF/ID and ID/EX are both invalid after the edge.
- **ms** for N cycles freezes all registers for N cycles. The pipe advances on the cycle where `mem_ready` = 1.
- While `RST` = 0:
  - `state` = RUN and both counters = 0.
  - All `WEN` = 1; `kill_if`, `kill_id`, `pc_sel` and `halted` = 0.
  - This holds immediately and asynchronously, including mid-stall or mid-drain.
- On the first cycle after reset, with idle inputs, all `WEN` = 0.

## Test plan
- **Load-use**: load `x5` in EX, add in ID reading `x5`.
  - Expect 1 cycle of `WEN_pc` = `WEN_ifid` = 1 and `kill_id` = 1.
  - Next cycle all `WEN` = 0; `stall_cnt` = 1.
  - Repeat with `Rdst_ex` = 0: expect no stall.
- **Redirect**: `redirect_ex` = 1 with `valid_ex` = 1.
  - Expect `pc_sel` = 1 and `kill_if` = `kill_id` = 1 for one cycle; `flush_cnt` = 1.
  - Repeat with **lu** also true: expect the redirect outputs and `stall_cnt` unchanged.
- **Memory wait**: `mem_req_mem` = 1 with `mem_ready` low for 3 cycles.
  - Expect all `WEN` = 1 for 3 cycles, then 0 when `mem_ready` = 1; `stall_cnt` = 3.
  - Assert `redirect_ex` during the wait: `pc_sel` stays 0 until release, then `pc_sel` = 1.
- **Halt drain**:
  - `halt_id`/`valid_id` → `state` = 1 at the next negedge, with `WEN_pc` = 1 and `kill_if` = 1.
  - Three cycles later, `halt_wb`/`valid_wb` → `state` = 2, `halted` = 1 and all `WEN` = 1, sustained for 10 cycles.
- **Reset mid-drain**: drop `RST` asynchronously while in DRAIN with counters at nonzero values.
  - Immediately `state` = 0, counters = 0 and `halted` = 0.
- **Saturation**: with `CNT_W` = 4, hold **ms** for 20 cycles.
  - `stall_cnt` stops at 15.
